// File: rtl/systolic_feeder_2by2.sv
// systolic_feeder_2by2: buffered, skewed, zero-padded operand feeder for systolic_2by2 (SYSTOLIC_FEED_REVERSE_EN selects descending read order)
module systolic_feeder_2by2 #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 4,
  parameter int LANE_SKEW = 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [1:0]        wr_sel,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  output logic              busy,
  output logic              feed_valid,
  output logic              done,
  output logic [DATA_W-1:0] up1,
  output logic [DATA_W-1:0] up2,
  output logic [DATA_W-1:0] left1,
  output logic [DATA_W-1:0] left2
);
`ifdef SYSTOLIC_FEED_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif
  localparam int L = DEPTH + LANE_SKEW;
  localparam int CW = $clog2(L);
  localparam logic [1:0] IDLE = 2'd0, FEED = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [CW-1:0] c, nc;
  logic [DATA_W-1:0] mem [4][DEPTH];
  logic [DATA_W-1:0] nmem [4][DEPTH];
  logic go, last, feeding, v1, v2;
  int k1, k2;
  logic [AW-1:0] r1, r2;
  // next buffer contents (same-edge write forwarded to the first read) and next feed cycle lookup
  always_comb begin
    nmem = mem;
    if (wr_en && state != FEED && int'(wr_addr) < DEPTH) nmem[wr_sel][wr_addr] = wr_data;
    go = start && state != FEED;
    last = state == FEED && int'(c) == L - 1;
    feeding = go || (state == FEED && !last);
    nc = go ? '0 : c + CW'(1);
    k1 = int'(nc);
    k2 = k1 - LANE_SKEW;
    v1 = k1 < DEPTH;
    v2 = k2 >= 0;
    r1 = AW'(REV ? DEPTH - 1 - k1 : k1);
    r2 = AW'(REV ? DEPTH - 1 - k2 : k2);
  end
  // buffers, sequencing and registered stream outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < DEPTH; j++) mem[i][j] <= '0;
      state <= IDLE;
      c <= '0;
      busy <= 1'b0;
      feed_valid <= 1'b0;
      done <= 1'b0;
      up1 <= '0;
      up2 <= '0;
      left1 <= '0;
      left2 <= '0;
    end else begin
      mem <= nmem;
      state <= feeding ? FEED : last ? DONE : IDLE;
      c <= feeding ? nc : '0;
      busy <= feeding;
      feed_valid <= feeding;
      done <= last;
      up1 <= feeding && v1 ? nmem[0][r1] : '0;
      up2 <= feeding && v2 ? nmem[1][r2] : '0;
      left1 <= feeding && v1 ? nmem[2][r1] : '0;
      left2 <= feeding && v2 ? nmem[3][r2] : '0;
    end
  end
endmodule
